// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, the per-requester
// access bundle and the lock counter width.
// Optional build macro used by the arbiter: DMEM_ARB_STATS_EN.
package dmem_arbiter_pkg;

    typedef logic [31:0] word_t;

    // Arbiter mode: free round-robin or held by a single owner for a burst
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // One requester's access as presented to the memory port
    typedef struct packed {
        word_t      addr;
        logic       read_enable;
        logic [3:0] write_mask;
        word_t      write_data;
    } arb_req_t;

    // Lock counter is a fixed 8-bit saturating counter
    localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the data-memory arbiter.
// The arbiter connects through the slave modport; the environment (requesters
// plus memory) uses the master modport.
// With DMEM_ARB_STATS_EN defined, per-requester grant/wait counters are added.
interface dmem_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    import dmem_arbiter_pkg::*;

    // Requester side
    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0]             req_lock_i;
    logic [NUM_REQ-1:0][31:0]       req_addr_i;
    logic [NUM_REQ-1:0]             req_read_enable_i;
    logic [NUM_REQ-1:0][3:0]        req_write_mask_i;
    logic [NUM_REQ-1:0][31:0]       req_write_data_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic [NUM_REQ-1:0]             rsp_valid_o;
    word_t                          rsp_data_o;

    // Memory side
    word_t                          mem_addr_o;
    logic                           mem_read_enable_o;
    logic [3:0]                     mem_write_mask_o;
    word_t                          mem_write_data_o;
    word_t                          mem_read_data_i;

`ifdef DMEM_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0]       stats_grant_o;
    logic [NUM_REQ-1:0][31:0]       stats_wait_o;
`endif

    modport slave (
        input  req_valid_i,
        input  req_lock_i,
        input  req_addr_i,
        input  req_read_enable_i,
        input  req_write_mask_i,
        input  req_write_data_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_data_o,
        output mem_addr_o,
        output mem_read_enable_o,
        output mem_write_mask_o,
        output mem_write_data_o,
`ifdef DMEM_ARB_STATS_EN
        output stats_grant_o,
        output stats_wait_o,
`endif
        input  mem_read_data_i
    );

    modport master (
        output req_valid_i,
        output req_lock_i,
        output req_addr_i,
        output req_read_enable_i,
        output req_write_mask_i,
        output req_write_data_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_data_o,
        input  mem_addr_o,
        input  mem_read_enable_o,
        input  mem_write_mask_o,
        input  mem_write_data_o,
`ifdef DMEM_ARB_STATS_EN
        input  stats_grant_o,
        input  stats_wait_o,
`endif
        output mem_read_data_i
    );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: starting at ptr and moving upward modulo
// NUM_REQ, selects the first asserted bit of valid. Returns a one-hot grant,
// the winner index and a flag telling whether anything was selected.
module dmem_arbiter_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Rotating priority search; the first hit from ptr wins
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && valid[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous-read memory port among NUM_REQ
// requesters with round-robin priority and an optional bounded burst lock.
// Grants and memory-port drive are combinational in the request cycle; read
// data returns to the granted requester on the following cycle.
// Build option: DMEM_ARB_STATS_EN adds per-requester grant and wait counters.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_LOCK = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    dmem_arbiter_if.slave  bus
);

    localparam int                    IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);
    // A limit of one grant means a lock can never extend past the first access
    localparam bit                    LOCK_EN    = (MAX_LOCK > 1);

    // Increment a requester index with wrap from the last requester to 0
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    // Lock counter increment that sticks at MAX_LOCK instead of wrapping
    function automatic logic [LOCK_CNT_W-1:0] sat_inc(input logic [LOCK_CNT_W-1:0] c);
        return (c >= MAX_LOCK_C) ? c : c + LOCK_CNT_W'(1);
    endfunction

    arb_state_t                 state, state_n;
    logic [IDX_W-1:0]           ptr, ptr_n;
    logic [IDX_W-1:0]           owner, owner_n;
    logic [LOCK_CNT_W-1:0]      lock_cnt, lock_cnt_n, lock_cnt_inc;
    logic [NUM_REQ-1:0]         rsp_vld_p1, rsp_vld_n;

    logic [NUM_REQ-1:0]         pick_grant;
    logic [IDX_W-1:0]           pick_idx;
    logic                       pick_any;

    logic [NUM_REQ-1:0]         grant;
    logic [IDX_W-1:0]           win_idx;
    logic                       win_any;

    arb_req_t [NUM_REQ-1:0]     reqs;
    arb_req_t                   sel;

    dmem_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid (bus.req_valid_i),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Gather each requester's access fields into one bundle per requester
    always_comb begin
        reqs = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].addr        = bus.req_addr_i[i];
            reqs[i].read_enable = bus.req_read_enable_i[i];
            reqs[i].write_mask  = bus.req_write_mask_i[i];
            reqs[i].write_data  = bus.req_write_data_i[i];
        end
    end

    assign lock_cnt_inc = sat_inc(lock_cnt);

    // Grant selection and next state for pointer, lock owner and lock counter
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        owner_n    = owner;
        lock_cnt_n = lock_cnt;
        grant      = '0;
        win_idx    = pick_idx;
        win_any    = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    grant   = pick_grant;
                    win_any = 1'b1;
                    ptr_n   = next_idx(pick_idx);
                    if (LOCK_EN && bus.req_lock_i[pick_idx]) begin
                        state_n    = LOCKED;
                        owner_n    = pick_idx;
                        lock_cnt_n = LOCK_CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                // Only the owner can be served; the exit cycle's access is still its own
                win_idx = owner;
                if (bus.req_valid_i[owner]) begin
                    grant      = NUM_REQ'(1) << owner;
                    win_any    = 1'b1;
                    lock_cnt_n = lock_cnt_inc;
                    if (!bus.req_lock_i[owner] || lock_cnt_inc >= MAX_LOCK_C) begin
                        state_n    = IDLE;
                        ptr_n      = next_idx(owner);
                        lock_cnt_n = '0;
                    end
                end else begin
                    state_n    = IDLE;
                    ptr_n      = next_idx(owner);
                    lock_cnt_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Nothing is granted while reset is held
        if (reset_i) begin
            grant   = '0;
            win_any = 1'b0;
        end
    end

    // Memory-port drive from the winner; quiet port when nothing is granted
    always_comb begin
        sel = reqs[win_idx];
        if (!win_any) begin
            sel = '0;
        end
        rsp_vld_n = sel.read_enable ? grant : '0;
    end

    assign bus.req_ready_o       = grant;
    assign bus.mem_addr_o        = sel.addr;
    assign bus.mem_read_enable_o = sel.read_enable;
    assign bus.mem_write_mask_o  = sel.write_mask;
    assign bus.mem_write_data_o  = sel.write_data;

    // Control state: FSM, round-robin pointer, lock owner/counter, read-return tag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            lock_cnt   <= '0;
            rsp_vld_p1 <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            owner      <= owner_n;
            lock_cnt   <= lock_cnt_n;
            rsp_vld_p1 <= rsp_vld_n;
        end
    end

    // Read data arrives from memory one cycle after the grant; a reset in that
    // cycle suppresses the response.
    assign bus.rsp_valid_o = reset_i ? '0 : rsp_vld_p1;
    assign bus.rsp_data_o  = (|bus.rsp_valid_o) ? bus.mem_read_data_i : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] grant_cnt;
    logic [NUM_REQ-1:0][31:0] wait_cnt;

    // Per-requester grant and wait-cycle counters, wrapping at 2^32
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grant_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
                if (bus.req_valid_i[i] && !grant[i]) begin
                    wait_cnt[i] <= wait_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign bus.stats_grant_o = grant_cnt;
    assign bus.stats_wait_o  = wait_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a BRAM-like memory model on the port, plus a
// behavioural reference of the arbitration rules (pointer, lock ownership,
// response return) and a shadow copy of memory contents.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int ML = 8;
    localparam int IW = (NR > 1) ? $clog2(NR) : 1;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.NUM_REQ(NR)) bus ();

    dmem_arbiter #(.NUM_REQ(NR), .MAX_LOCK(ML)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h40) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    // Synchronous-read memory: read returns pre-write contents
    logic [31:0] ram [256];
    logic [31:0] rdata;
    bit          ram_ready;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else begin
            if (bus.mem_read_enable_o) rdata <= ram[bus.mem_addr_o[9:2]];
            for (int b = 0; b < 4; b++)
                if (bus.mem_write_mask_o[b])
                    ram[bus.mem_addr_o[9:2]][8*b +: 8] <= bus.mem_write_data_o[8*b +: 8];
        end
    end
    assign bus.mem_read_data_i = rdata;

    // Reference model state
    logic [31:0] shadow [256];
    int          m_ptr, m_owner, m_cnt, m_pend, m_win;
    bit          m_locked;
    logic [31:0] m_pend_data;
    logic [NR-1:0]    exp_ready;
    logic [68:0]      exp_mem, care_mem;
    logic [NR+31:0]   exp_rsp, care_rsp;

    function automatic void model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_pend = -1; m_locked = 0;
    endfunction

    function automatic void model_eval();
        logic [IW-1:0] w;
        m_win = -1;
        if (m_locked) begin
            if (bus.req_valid_i[IW'(m_owner)]) m_win = m_owner;
        end else begin
            for (int k = 0; k < NR; k++)
                if (m_win < 0 && bus.req_valid_i[IW'((m_ptr + k) % NR)]) m_win = (m_ptr + k) % NR;
        end
        exp_ready = '0;
        exp_mem   = '0;
        care_mem  = {1'b1, 4'hF, 64'h0};
        if (m_win >= 0) begin
            w         = IW'(m_win);
            exp_ready = NR'(1) << m_win;
            exp_mem   = {bus.req_read_enable_i[w], bus.req_write_mask_i[w],
                         bus.req_addr_i[w], bus.req_write_data_i[w]};
            care_mem  = '1;
        end
        exp_rsp  = '0;
        care_rsp = {{NR{1'b1}}, 32'h0};
        if (m_pend >= 0) begin
            exp_rsp  = {NR'(1) << m_pend, m_pend_data};
            care_rsp = '1;
        end
    endfunction

    function automatic void model_commit();
        logic [IW-1:0] w;
        logic [7:0]    ix;
        int            np;
        bit            leave;
        np = -1;
        w  = IW'(m_win);
        if (m_win >= 0) begin
            ix = bus.req_addr_i[w][9:2];
            if (bus.req_read_enable_i[w]) begin
                np = m_win;
                m_pend_data = shadow[ix];
            end
            for (int b = 0; b < 4; b++)
                if (bus.req_write_mask_i[w][b]) shadow[ix][8*b +: 8] = bus.req_write_data_i[w][8*b +: 8];
        end
        m_pend = np;
        if (!m_locked) begin
            if (m_win >= 0) begin
                m_ptr = (m_win + 1) % NR;
                if (bus.req_lock_i[w] && ML > 1) begin
                    m_locked = 1; m_owner = m_win; m_cnt = 1;
                end
            end
        end else begin
            leave = 1;
            if (m_win >= 0) begin
                if (m_cnt < ML) m_cnt = m_cnt + 1;
                leave = !bus.req_lock_i[w] || (m_cnt >= ML);
            end
            if (leave) begin
                m_locked = 0; m_ptr = (m_owner + 1) % NR; m_cnt = 0;
            end
        end
    endfunction

    task automatic clear_reqs();
        bus.req_valid_i = '0; bus.req_lock_i = '0; bus.req_addr_i = '0;
        bus.req_read_enable_i = '0; bus.req_write_mask_i = '0; bus.req_write_data_i = '0;
    endtask

    task automatic set_req(input int r, input bit v, input bit lk, input bit rd,
                           input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid_i[IW'(r)]       = v;
        bus.req_lock_i[IW'(r)]        = lk;
        bus.req_read_enable_i[IW'(r)] = rd;
        bus.req_write_mask_i[IW'(r)]  = m;
        bus.req_addr_i[IW'(r)]        = a;
        bus.req_write_data_i[IW'(r)]  = d;
    endtask

    function automatic logic [31:0] rand_addr();
        return {22'h0, 8'($urandom), 2'b00};
    endfunction

    task automatic do_reset(input int n);
        reset_i = 1'b1;
        clear_reqs();
        repeat (n) @(negedge clk);
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            set_req(0, 1, 0, 1, 4'hF, rand_addr(), $urandom);
            set_req(1, 1, 1, 1, 4'h3, rand_addr(), $urandom);
            #2;
            checks++;
            if (bus.req_ready_o !== '0 || bus.rsp_valid_o !== '0) begin
                failures++;
                $display("FAIL reset_ctrl: ready=%b rsp_valid=%b, required 0", bus.req_ready_o, bus.rsp_valid_o);
            end
            checks++;
            if ({bus.mem_read_enable_o, bus.mem_write_mask_o, bus.mem_addr_o, bus.mem_write_data_o} !== 69'h0) begin
                failures++;
                $display("FAIL reset_mem: rd=%b mask=%b addr=%h data=%h, required all 0",
                         bus.mem_read_enable_o, bus.mem_write_mask_o, bus.mem_addr_o, bus.mem_write_data_o);
            end
        end
        @(negedge clk);
        clear_reqs();
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_single_read();
        do_reset(1);
        for (int c = 0; c < 2; c++) begin
            clear_reqs();
            if (c == 0) set_req(0, 1, 0, 1, 4'h0, 32'h100, 32'h0);
            #2; model_eval();
            checks++;
            if (bus.req_ready_o !== exp_ready || (c == 0 && bus.req_ready_o !== 2'b01)) begin
                failures++; $display("FAIL single_ready c%0d: got %b want %b", c, bus.req_ready_o, exp_ready);
            end
            checks++;
            if (({bus.mem_read_enable_o, bus.mem_write_mask_o, bus.mem_addr_o, bus.mem_write_data_o} & care_mem) !== exp_mem) begin
                failures++; $display("FAIL single_mem c%0d: rd=%b addr=%h want %h", c, bus.mem_read_enable_o, bus.mem_addr_o, exp_mem);
            end
            checks++;
            if (({bus.rsp_valid_o, bus.rsp_data_o} & care_rsp) !== exp_rsp ||
                (c == 1 && (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 32'hDEADBEEF || bus.mem_read_enable_o !== 1'b0))) begin
                failures++; $display("FAIL single_rsp c%0d: valid=%b data=%h want valid=01 data=deadbeef", c, bus.rsp_valid_o, bus.rsp_data_o);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_alternate();
        do_reset(1);
        for (int c = 0; c < 7; c++) begin
            clear_reqs();
            if (c < 6) begin
                set_req(0, 1, 0, 1, 4'h0, rand_addr(), 32'h0);
                set_req(1, 1, 0, 1, 4'h0, rand_addr(), 32'h0);
            end
            #2; model_eval();
            checks++;
            if (bus.req_ready_o !== exp_ready || (c < 6 && bus.req_ready_o !== ((c % 2 == 0) ? 2'b01 : 2'b10))) begin
                failures++; $display("FAIL alternate_ready c%0d: got %b want %b", c, bus.req_ready_o, exp_ready);
            end
            checks++;
            if (({bus.mem_read_enable_o, bus.mem_write_mask_o, bus.mem_addr_o, bus.mem_write_data_o} & care_mem) !== exp_mem) begin
                failures++; $display("FAIL alternate_mem c%0d: addr=%h want %h", c, bus.mem_addr_o, exp_mem);
            end
            checks++;
            if (({bus.rsp_valid_o, bus.rsp_data_o} & care_rsp) !== exp_rsp) begin
                failures++; $display("FAIL alternate_rsp c%0d: valid=%b data=%h want %h", c, bus.rsp_valid_o, bus.rsp_data_o, exp_rsp);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_lock_max();
        logic [1:0] want [12] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                  2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
        do_reset(1);
        for (int c = 0; c < 13; c++) begin
            clear_reqs();
            if (c < 12) begin
                set_req(0, 1, 0, 1, 4'h0, rand_addr(), 32'h0);
                set_req(1, 1, 1, 1, 4'h0, rand_addr(), 32'h0);
            end
            #2; model_eval();
            checks++;
            if (bus.req_ready_o !== exp_ready || (c < 12 && bus.req_ready_o !== want[c])) begin
                failures++; $display("FAIL lock_max_ready c%0d: got %b want %b", c, bus.req_ready_o, exp_ready);
            end
            checks++;
            if (({bus.rsp_valid_o, bus.rsp_data_o} & care_rsp) !== exp_rsp) begin
                failures++; $display("FAIL lock_max_rsp c%0d: valid=%b data=%h want %h", c, bus.rsp_valid_o, bus.rsp_data_o, exp_rsp);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_lock_release();
        logic [1:0] want [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        do_reset(1);
        for (int c = 0; c < 6; c++) begin
            clear_reqs();
            set_req(0, 1, 0, 1, 4'h0, rand_addr(), 32'h0);
            set_req(1, 1, (c <= 2), 1, 4'h0, rand_addr(), 32'h0);
            #2; model_eval();
            checks++;
            if (bus.req_ready_o !== exp_ready || bus.req_ready_o !== want[c]) begin
                failures++; $display("FAIL lock_release_ready c%0d: got %b want %b", c, bus.req_ready_o, want[c]);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_write_merge();
        logic [31:0] old_word;
        logic [31:0] merged;
        old_word = init_word(32'h80);
        merged   = {old_word[31:16], 16'h5678};
        do_reset(1);
        for (int c = 0; c < 3; c++) begin
            clear_reqs();
            if (c == 0) set_req(0, 1, 0, 0, 4'b0011, 32'h200, 32'h12345678);
            if (c == 1) set_req(0, 1, 0, 1, 4'b0000, 32'h200, 32'h0);
            #2; model_eval();
            checks++;
            if (({bus.mem_read_enable_o, bus.mem_write_mask_o, bus.mem_addr_o, bus.mem_write_data_o} & care_mem) !== exp_mem ||
                (c == 0 && bus.mem_write_mask_o !== 4'b0011)) begin
                failures++; $display("FAIL write_mem c%0d: mask=%b data=%h want %h", c, bus.mem_write_mask_o, bus.mem_write_data_o, exp_mem);
            end
            checks++;
            if (({bus.rsp_valid_o, bus.rsp_data_o} & care_rsp) !== exp_rsp ||
                (c == 1 && bus.rsp_valid_o !== 2'b00) ||
                (c == 2 && (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== merged))) begin
                failures++; $display("FAIL write_rsp c%0d: valid=%b data=%h want merged %h", c, bus.rsp_valid_o, bus.rsp_data_o, merged);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        clear_reqs();
        set_req(0, 1, 0, 1, 4'h0, 32'h100, 32'h0);
        #2;
        checks++;
        if (bus.req_ready_o !== 2'b01) begin
            failures++; $display("FAIL reset_mid_grant: got %b want 01", bus.req_ready_o);
        end
        @(negedge clk);
        reset_i = 1'b1;
        set_req(1, 1, 1, 1, 4'h0, 32'h104, 32'h0);
        #2;
        checks++;
        if (bus.rsp_valid_o !== 2'b00 || bus.req_ready_o !== 2'b00) begin
            failures++; $display("FAIL reset_mid_rsp: valid=%b ready=%b want 00 00", bus.rsp_valid_o, bus.req_ready_o);
        end
        checks++;
        if ({bus.mem_read_enable_o, bus.mem_write_mask_o, bus.mem_addr_o, bus.mem_write_data_o} !== 69'h0) begin
            failures++; $display("FAIL reset_mid_mem: rd=%b addr=%h want 0", bus.mem_read_enable_o, bus.mem_addr_o);
        end
        @(negedge clk);
        reset_i = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            #2; model_eval();
            checks++;
            if (bus.req_ready_o !== exp_ready || (c == 0 && bus.req_ready_o !== 2'b01)) begin
                failures++; $display("FAIL reset_mid_after c%0d: got %b want %b", c, bus.req_ready_o, exp_ready);
            end
            checks++;
            if (({bus.rsp_valid_o, bus.rsp_data_o} & care_rsp) !== exp_rsp) begin
                failures++; $display("FAIL reset_mid_after_rsp c%0d: valid=%b want %h", c, bus.rsp_valid_o, exp_rsp);
            end
            model_commit();
            @(negedge clk);
            clear_reqs();
        end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < NR; r++)
                set_req(r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, rand_addr(), $urandom);
            #2; model_eval();
            checks++;
            if (bus.req_ready_o !== exp_ready) begin
                failures++; $display("FAIL random_ready c%0d: got %b want %b", c, bus.req_ready_o, exp_ready);
            end
            checks++;
            if (({bus.mem_read_enable_o, bus.mem_write_mask_o, bus.mem_addr_o, bus.mem_write_data_o} & care_mem) !== exp_mem) begin
                failures++; $display("FAIL random_mem c%0d: rd=%b mask=%b addr=%h data=%h want %h", c,
                                     bus.mem_read_enable_o, bus.mem_write_mask_o, bus.mem_addr_o, bus.mem_write_data_o, exp_mem);
            end
            checks++;
            if (({bus.rsp_valid_o, bus.rsp_data_o} & care_rsp) !== exp_rsp) begin
                failures++; $display("FAIL random_rsp c%0d: valid=%b data=%h want %h", c, bus.rsp_valid_o, bus.rsp_data_o, exp_rsp);
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        clear_reqs();
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        model_reset();
        test_reset();
        test_single_read();
        test_alternate();
        test_lock_max();
        test_lock_release();
        test_write_merge();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares a single data-memory port between NUM_REQ requesters on one memory port, with the same 1-cycle synchronous-read timing as the CPU dmem bus. Requester 0 is the CPU memory-access stage; the others are future DMA and debug masters.
- Arbitration is round-robin, with an optional bounded lock so one requester can hold the port for a burst.
- The block sits between the requesters and the data BRAM/bus fabric, and drives the memory port's address, read-enable, write-mask and write-data signals.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_LOCK, 8, maximum consecutive grants while locked (1..255).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester access request.
- req_lock_i  in  NUM_REQ  requester asks to keep the grant after this access.
- req_addr_i  in  NUM_REQ x 32  word_t address per requester.
- req_read_enable_i  in  NUM_REQ  read access.
- req_write_mask_i  in  NUM_REQ x 4  byte write mask (0 = no write).
- req_write_data_i  in  NUM_REQ x 32  write data.
- req_ready_o  out  NUM_REQ  one-hot; the access is accepted this cycle.
- rsp_valid_o  out  NUM_REQ  one-hot; read data valid for that requester.
- rsp_data_o  out  32  read data (shared; qualified by rsp_valid_o).
- mem_addr_o  out  32  memory address.
- mem_read_enable_o  out  1  memory read strobe.
- mem_write_mask_o  out  4  memory byte write mask.
- mem_write_data_o  out  32  memory write data.
- mem_read_data_i  in  32  memory read data, one cycle after mem_read_enable_o.

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values:
  - req_ready_o = 0, rsp_valid_o = 0.
  - mem_read_enable_o = 0, mem_write_mask_o = 0.
  - mem_addr_o and mem_write_data_o = 0.
  - FSM = IDLE, round-robin pointer = 0, lock counter = 0.
- Grant (combinational within the cycle):
  - Winner = first requester with req_valid_i set, searching from the pointer upward modulo NUM_REQ.
  - req_ready_o[winner] = 1.
  - The winner's addr, read-enable, mask and data drive the mem_* outputs in the same cycle.
  - With no valid request: mem_read_enable_o = 0 and mem_write_mask_o = 0.
- Throughput: one access per cycle with no bubbles between different requesters.
- Pointer: after each grant in IDLE, the pointer becomes winner+1 (wraps NUM_REQ-1 -> 0).
- Response pipeline: a read granted at cycle N produces rsp_valid_o[winner] = 1 and rsp_data_o = mem_read_data_i at cycle N+1. Writes produce no response.
- FSM states:
  - IDLE: a grant with req_lock_i[winner] = 1 -> LOCKED, owner = winner, lock counter = 1.
  - LOCKED: only the owner may be granted; others see req_ready_o = 0.
    - Each owner grant increments the counter.
    - Exit to IDLE when the owner deasserts req_lock_i, or drops req_valid_i for a cycle, or the counter reaches MAX_LOCK.
    - On exit, the pointer = owner+1. The exit cycle's access, if any, still belongs to the owner.
- Simultaneous read and write in one request: both are forwarded; the response returns pre-write memory data, as the BRAM does.
- Reset mid-operation: a pending response is discarded (no rsp_valid_o on the following cycle), the lock is dropped and the pointer is cleared.
- Width rule: the lock counter is 8 bits and saturates at MAX_LOCK, never wrapping.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds per-requester 32-bit grant counters and wait counters. A wait cycle is valid and not ready.
  - Counters wrap at 2^32 and clear on reset.
  - They are exposed on stats_grant_o and stats_wait_o (NUM_REQ x 32).
- Not defined: those ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cpu_common holds arb_state_t (IDLE, LOCKED) and the arb_req_t struct (addr, read_enable, write_mask, write_data).
- One natural sub-module: rr_picker. It is combinational; given the valid vector and the pointer, it returns a one-hot grant and the winner index. It is reusable by later interconnect arbiters.

Test Plan:
- Single requester: req 0 reads addr 0x100 (memory holds 0xDEADBEEF) -> req_ready_o = 01 at cycle N; rsp_valid_o = 01 with rsp_data_o = 0xDEADBEEF at N+1; mem_read_enable_o = 0 afterwards.
- Both requesters continuously valid, no lock -> grants alternate 01, 10, 01, 10 over 4 cycles; each response is routed to the correct requester.
- Req 1 locked and valid for 12 cycles, MAX_LOCK = 8, req 0 also valid:
  - Req 1 is granted 8 consecutive cycles, then req 0 is granted once.
  - Req 1 may then re-lock.
- Lock release: req 1 drops req_lock_i after 3 grants -> req 0 is granted the following cycle; the pointer then favours requester 0+1.
- Write with mask 0b0011, data 0x12345678 at 0x200 -> mem_write_mask_o = 0011 for one cycle; no rsp_valid_o. A subsequent read returns the merged bytes.
- Reset asserted the cycle after a read grant -> no rsp_valid_o appears; all outputs hold their reset values; the first grant after reset goes to requester 0.
